// File: rtl/serial_sub8.sv
// Bit-serial subtractor: D_8 = A_8 - B_8 - Bin, one full-subtractor cell, LSB first.
// start/busy/done handshake; result, borrow-out and signed overflow held until next accept.
module serial_sub8 #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A_8,
  input  logic [WIDTH-1:0] B_8,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D_8,
  output logic             Bout,
  output logic             V
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE_ST} state_t;

  state_t             state;
  logic [WIDTH-1:0]   a_sh;
  logic [WIDTH-1:0]   b_sh;
  logic [WIDTH-2:0]   res_sh;
  logic               br;
  logic [CNT_W-1:0]   count;
  logic               sign_a;
  logic               sign_b;

  logic               a0_c;
  logic               b0_c;
  logic               diff_c;
  logic               br_nxt_c;
  logic               last_c;

  // Full-subtractor cell on the current LSBs
  always_comb begin
    a0_c     = a_sh[0];
    b0_c     = b_sh[0];
    diff_c   = a0_c ^ b0_c ^ br;
    br_nxt_c = (~a0_c & b0_c) | (~(a0_c ^ b0_c) & br);
    last_c   = (count == CNT_W'(WIDTH - 1));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      br     <= 1'b0;
      count  <= '0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      D_8    <= '0;
      Bout   <= 1'b0;
      V      <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE_ST: begin
          done <= 1'b0;
          if (start) begin
            a_sh   <= A_8;
            b_sh   <= B_8;
            br     <= Bin;
            res_sh <= '0;
            count  <= '0;
            sign_a <= A_8[WIDTH-1];
            sign_b <= B_8[WIDTH-1];
            D_8    <= '0;
            busy   <= 1'b1;
            state  <= SHIFT;
          end else begin
            state  <= IDLE;
          end
        end
        SHIFT: begin
          a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
          br     <= br_nxt_c;
          res_sh <= {diff_c, res_sh[WIDTH-2:1]};
          count  <= count + CNT_W'(1);
          // Final bit: publish result straight from the cell outputs
          if (last_c) begin
            D_8   <= {diff_c, res_sh};
            Bout  <= br_nxt_c;
            V     <= (sign_a != sign_b) && (diff_c != sign_a);
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE_ST;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub8.sv
// Self-checking bench for serial_sub8: scoreboard of expected results popped on done.
module tb_serial_sub8;

  localparam int unsigned WIDTH = 8;

  logic             clk;
  logic             reset_n;
  logic             start;
  logic [WIDTH-1:0] A_8;
  logic [WIDTH-1:0] B_8;
  logic             Bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] D_8;
  logic             Bout;
  logic             V;

  typedef struct {
    logic [WIDTH-1:0] d;
    logic             bout;
    logic             v;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   errors   = 0;
  int   busy_run = 0;
  int   done_cnt = 0;

  serial_sub8 #(.WIDTH(WIDTH), .CNT_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .A_8(A_8), .B_8(B_8), .Bin(Bin),
    .busy(busy), .done(done), .D_8(D_8), .Bout(Bout), .V(V)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference: modular subtract, unsigned borrow, signed overflow
  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic bi);
    exp_t e;
    logic [WIDTH:0] full;
    full   = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, bi};
    e.d    = full[WIDTH-1:0];
    e.bout = ({1'b0, a} < ({1'b0, b} + {{WIDTH{1'b0}}, bi}));
    e.v    = (a[WIDTH-1] != b[WIDTH-1]) && (e.d[WIDTH-1] != a[WIDTH-1]);
    return e;
  endfunction

  // Done monitor: pops scoreboard, checks result and busy length
  always @(negedge clk) begin
    if (busy) busy_run++;
    if (done) begin
      exp_t e;
      done_cnt++;
      if (sb.size() == 0) begin
        check_eq("unexpected_done", 32'(done), 32'd0);
      end else begin
        e = sb.pop_front();
        check_eq("D_8",  32'(D_8),  32'(e.d));
        check_eq("Bout", 32'(Bout), 32'(e.bout));
        check_eq("V",    32'(V),    32'(e.v));
      end
      check_eq("busy_len", 32'(busy_run), 32'(WIDTH));
      busy_run = 0;
    end
  end

  // Drive one request at the current negedge and record its expected result
  task automatic drive_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic bi);
    A_8   = a;
    B_8   = b;
    Bin   = bi;
    start = 1'b1;
    sb.push_back(model(a, b, bi));
  endtask

  // Wait (bounded) for done; returns negedges elapsed
  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!done) check_eq("done_timeout", 32'(n), 32'd0);
  endtask

  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic bi);
    int n;
    drive_op(a, b, bi);
    @(negedge clk);
    start = 1'b0;
    wait_done(n);
    check_eq("latency", 32'(n + 1), 32'(WIDTH + 1));
    @(negedge clk);
    check_eq("done_pulse", 32'(done), 32'd0);
  endtask

  initial begin
    int n;
    int dc;
    exp_t e;
    reset_n = 1'b0;
    start   = 1'b0;
    A_8     = '0;
    B_8     = '0;
    Bin     = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_D_8",  32'(D_8),  32'd0);
    check_eq("rst_Bout", 32'(Bout), 32'd0);
    check_eq("rst_V",    32'(V),    32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Directed vectors
    run_op(8'h34, 8'h12, 1'b0);
    check_eq("hold_D_8", 32'(D_8), 32'h22);
    run_op(8'h12, 8'h34, 1'b0);
    run_op(8'h00, 8'h00, 1'b1);
    check_eq("wrap_D_8", 32'(D_8), 32'hFF);
    run_op(8'h80, 8'h08, 1'b0);
    check_eq("ovf_V", 32'(V), 32'd1);
    run_op(8'h55, 8'hAA, 1'b1);

    // Start held high, inputs scrambled mid-shift, back-to-back accept on DONE
    drive_op(8'h72, 8'h27, 1'b1);
    repeat (3) @(negedge clk);
    A_8 = 8'hC3;
    B_8 = 8'h5A;
    Bin = 1'b0;
    wait_done(n);
    check_eq("b2b_latency", 32'(n + 3), 32'(WIDTH + 1));
    check_eq("b2b_D_8", 32'(D_8), 32'h4A);
    drive_op(8'h80, 8'h08, 1'b0);
    @(negedge clk);
    start = 1'b0;
    check_eq("b2b_busy", 32'(busy), 32'd1);
    check_eq("b2b_done_low", 32'(done), 32'd0);
    wait_done(n);
    check_eq("b2b2_latency", 32'(n + 1), 32'(WIDTH + 1));
    @(negedge clk);

    // Start pulsed while busy is ignored
    dc = done_cnt;
    drive_op(8'h12, 8'h34, 1'b0);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    A_8   = 8'hFF;
    B_8   = 8'h01;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(n);
    check_eq("ign_latency", 32'(n + 4), 32'(WIDTH + 1));
    repeat (12) @(negedge clk);
    check_eq("ign_single_done", 32'(done_cnt - dc), 32'd1);
    check_eq("ign_D_8", 32'(D_8), 32'hDE);
    check_eq("ign_busy", 32'(busy), 32'd0);

    // Reset mid-shift aborts without a done pulse
    dc = done_cnt;
    drive_op(8'h34, 8'h12, 1'b0);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_D_8",  32'(D_8),  32'd0);
    check_eq("abort_done", 32'(done), 32'd0);
    reset_n = 1'b1;
    e = sb.pop_back();
    busy_run = 0;
    repeat (12) @(negedge clk);
    check_eq("abort_no_done", 32'(done_cnt - dc), 32'd0);
    run_op(8'h34, 8'h12, 1'b0);
    check_eq("post_abort_D_8", 32'(D_8), 32'h22);

    // Random sweep including boundary operands
    for (int i = 0; i < 12; i++) begin
      logic [WIDTH-1:0] ra;
      logic [WIDTH-1:0] rb;
      ra = (i == 0) ? 8'hFF : WIDTH'($urandom_range(0, 255));
      rb = (i == 1) ? 8'hFF : WIDTH'($urandom_range(0, 255));
      run_op(ra, rb, 1'($urandom_range(0, 1)));
    end

    check_eq("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_sub8.md
Name: serial_sub8

Overview:
Bit-serial 8-bit subtractor computing D_8 = A_8 - B_8 - Bin. It is the sequential inverse-operation companion to the team's ripple-carry adder. It uses a single full-subtractor cell and a borrow flip-flop, processing one bit per clock, LSB first, under a start/busy/done handshake. It serves as a compact ALU subtract path and provides golden-value cross-checks against the adder datapath.

Parameters:
WIDTH, 8, operand and result width in bits; also the number of shift cycles.
CNT_W, 4, bit counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
clk  input  1  system clock, rising-edge
reset_n  input  1  asynchronous, active-low reset
start  input  1  request; sampled only when not busy
A_8  input  WIDTH  minuend, captured on accepted start
B_8  input  WIDTH  subtrahend, captured on accepted start
Bin  input  1  borrow-in, captured on accepted start
busy  output  1  high while shifting
done  output  1  single-cycle pulse when the result is valid
D_8  output  WIDTH  difference; held until the next accepted start
Bout  output  1  final borrow-out; 1 when A < B + Bin (unsigned)
V  output  1  signed two's-complement overflow

Behaviour:
- One clock domain, one reset; all flops reset asynchronously when reset_n = 0.
- Reset values: busy=0, done=0, D_8=0, Bout=0, V=0, state=IDLE, count=0, all internal shift registers 0.
- States:
  - IDLE: accepts start.
  - SHIFT: shifting one bit per cycle.
  - DONE: one cycle, done=1.
- Accept rule: start=1 in IDLE or DONE is accepted at that edge. On accept:
  - a_sh<=A_8, b_sh<=B_8, br<=Bin, count<=0, capture A_8[WIDTH-1] and B_8[WIDTH-1] for V.
  - state<=SHIFT, busy<=1.
  - D_8 is cleared at accept and is invalid until done.
- start while busy (SHIFT) is ignored; it is neither queued nor latched.
- SHIFT, per edge, using a0=a_sh[0], b0=b_sh[0]:
  - diff = a0^b0^br
  - br <= (~a0&b0) | (~(a0^b0)&br)
  - result shifts right with diff entering the MSB; a_sh and b_sh shift right; count++.
- When count reaches WIDTH-1 on a SHIFT edge, that edge processes the final bit. At the same edge:
  - state<=DONE, busy<=0, done<=1.
  - D_8<=final result; Bout<=final borrow.
  - V<=(sA!=sB)&&(D_8 MSB!=sA).
- Latency: start accepted at edge k gives busy=1 for cycles k+1..k+WIDTH and done=1 for the cycle after edge k+WIDTH (WIDTH+1 edges from accept to done).
- DONE → IDLE at the next edge, with done<=0, unless start=1, in which case a new operation is accepted (back-to-back, no bubble beyond the DONE cycle).
- D_8, Bout and V are stable from done until the next accept. Inputs A_8, B_8 and Bin are don't-care while busy.
- Wrap-around: results are modulo 2^WIDTH. 0-0-1 gives D_8=all ones, Bout=1.
- Reset asserted mid-SHIFT aborts the operation immediately: busy=0, no done pulse, outputs return to reset values.
- start held high continuously gives one operation per WIDTH+1 cycles.

Test Plan:
- A_8=0x34, B_8=0x12, Bin=0, 1-cycle start → after 9 edges done=1, D_8=0x22, Bout=0, V=0; busy high for exactly 8 cycles.
- A_8=0x12, B_8=0x34, Bin=0 → D_8=0xDE, Bout=1, V=0. A_8=0x00, B_8=0x00, Bin=1 → D_8=0xFF, Bout=1, V=0.
- A_8=0x80, B_8=0x08, Bin=0 → D_8=0x78, Bout=0, V=1. A_8=0x55, B_8=0xAA, Bin=1 → D_8=0xAA, Bout=1, V=1.
- A_8=0x72, B_8=0x27, Bin=1 with start held high → D_8=0x4A, Bout=0, V=0; next operation accepted on the DONE edge; change A_8/B_8 mid-shift → result unaffected.
- Pulse start again at busy cycle 3 → ignored: single done, busy not extended, result unchanged.
- reset_n low for 1 cycle at busy cycle 5 → busy=0, D_8=0, done never pulses; fresh start afterwards (0x34-0x12) yields 0x22 normally.
